// File: rtl/move_validator.sv
// move_validator: walks the board RAM in one direction from a placed square and
// reports whether the move brackets at least one opponent disc, and how many.
// The completion pulse and the result registers are all flops, so the
// controller can latch dir_status_o/run_len_o directly on s_done_o.
module move_validator #(
    parameter int BOARD_W = 10,
    parameter int CELLS   = BOARD_W * BOARD_W,
    parameter int ADDR_W  = 7,
    parameter int STEP_W  = 5,
    parameter int MAX_RUN = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ld,
    input  logic              enable,
    input  logic [STEP_W-1:0] step_in,
    input  logic              step_sign_in,
    input  logic [ADDR_W-1:0] pos_in,
    input  logic              player_in,
    input  logic [1:0]        mem_data_in,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              busy_o,
    output logic              s_done_o,
    output logic              dir_status_o,
    output logic [2:0]        run_len_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        STEP  = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cur;
    logic [2:0]        cnt;
    logic [STEP_W-1:0] step_q;
    logic              sign_q;
    logic [ADDR_W-1:0] pos_q;
    logic              player_q;

    logic [ADDR_W:0]   nxt;
    logic              out_of_range;
    logic [1:0]        opp_code;
    logic [1:0]        own_code;

    // Next address one extra bit wide so an underflow shows up as the top bit set;
    // the range check only matters for a corrupt pos_in, the border ring stops normal walks.
    always_comb begin
        nxt          = '0;
        out_of_range = 1'b0;
        if (sign_q)
            nxt = {1'b0, cur} - {{(ADDR_W + 1 - STEP_W){1'b0}}, step_q};
        else
            nxt = {1'b0, cur} + {{(ADDR_W + 1 - STEP_W){1'b0}}, step_q};
        out_of_range = nxt[ADDR_W] || (nxt >= (ADDR_W + 1)'(CELLS));
        opp_code     = player_q ? 2'b01 : 2'b10;
        own_code     = player_q ? 2'b10 : 2'b01;
    end

    // Scan FSM: one STEP/WAIT/CHECK round per cell read; DONE registers the
    // completion pulse, which is therefore visible the cycle after DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cur          <= '0;
            cnt          <= '0;
            step_q       <= '0;
            sign_q       <= 1'b0;
            pos_q        <= '0;
            player_q     <= 1'b0;
            mem_addr_o   <= '0;
            busy_o       <= 1'b0;
            s_done_o     <= 1'b0;
            dir_status_o <= 1'b0;
            run_len_o    <= '0;
        end else begin
            s_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld) begin
                        step_q   <= step_in;
                        sign_q   <= step_sign_in;
                        pos_q    <= pos_in;
                        player_q <= player_in;
                    end
                    if (enable) begin
                        cur          <= ld ? pos_in : pos_q;
                        cnt          <= '0;
                        dir_status_o <= 1'b0;
                        run_len_o    <= '0;
                        busy_o       <= 1'b1;
                        state        <= STEP;
                    end
                end
                STEP: begin
                    if (out_of_range) begin
                        state <= DONE;
                    end else begin
                        cur        <= nxt[ADDR_W-1:0];
                        mem_addr_o <= nxt[ADDR_W-1:0];
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (mem_data_in == opp_code) begin
                        if (cnt == 3'(MAX_RUN - 1)) begin
                            state <= DONE;
                        end else begin
                            cnt   <= cnt + 3'd1;
                            state <= STEP;
                        end
                    end else if ((mem_data_in == own_code) && (cnt != 3'd0)) begin
                        dir_status_o <= 1'b1;
                        run_len_o    <= cnt;
                        state        <= DONE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    s_done_o <= 1'b1;
                    busy_o   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
